// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one transaction at a time through IDLE -> ACCESS -> RESP.
// Optional round-robin arbitration with `define DMEM_ARB_RR_EN (default: m0 fixed priority).
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_func3,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_func3,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_func3,
  input  logic [31:0] mem_rdata,
  output logic        m0_stall
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      r_state, w_next;
  logic        r_we, r_owner;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [2:0]  r_func3;
  logic        w_gnt0, w_gnt1, w_idle, w_access, w_resp;

  // Every output is gated by rst so reset silences the block immediately.
  assign w_idle   = (r_state == IDLE)   && rst;
  assign w_access = (r_state == ACCESS) && rst;
  assign w_resp   = (r_state == RESP)   && rst;

`ifdef DMEM_ARB_RR_EN
  logic r_last; // 1 = m1 was granted most recently

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 r_last <= 1'b1;
    else if (w_gnt0 | w_gnt1) r_last <= w_gnt1;
  end

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_idle) begin
      if (m0_req && m1_req) begin
        w_gnt0 = r_last;
        w_gnt1 = !r_last;
      end else begin
        w_gnt0 = m0_req;
        w_gnt1 = m1_req;
      end
    end
  end
`else
  always_comb begin
    w_gnt0 = w_idle && m0_req;
    w_gnt1 = w_idle && m1_req && !m0_req;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_gnt0 || w_gnt1) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_func3 <= '0;
      r_rdata <= '0;
    end else begin
      if (w_gnt0 || w_gnt1) begin
        r_owner <= w_gnt1;
        r_we    <= w_gnt1 ? m1_we    : m0_we;
        r_addr  <= w_gnt1 ? m1_addr  : m0_addr;
        r_wdata <= w_gnt1 ? m1_wdata : m0_wdata;
        r_func3 <= w_gnt1 ? m1_func3 : m0_func3;
      end
      // Stores respond with zero data.
      if (r_state == ACCESS) r_rdata <= r_we ? 32'd0 : mem_rdata;
    end
  end

  always_comb begin
    m0_gnt    = w_gnt0;
    m1_gnt    = w_gnt1;
    m0_stall  = rst && m0_req && !w_gnt0;
    mem_read  = w_access && !r_we;
    mem_write = w_access && r_we;
    mem_addr  = w_access ? r_addr  : 32'd0;
    mem_wdata = w_access ? r_wdata : 32'd0;
    mem_func3 = w_access ? r_func3 : 3'd0;
    m0_rvalid = w_resp && !r_owner;
    m1_rvalid = w_resp && r_owner;
    m0_rdata  = m0_rvalid ? r_rdata : 32'd0;
    m1_rdata  = m1_rvalid ? r_rdata : 32'd0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model.
module tb_dmem_arbiter;
  logic        clk, rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_stall;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [2:0]  m0_func3;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [2:0]  m1_func3;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_func3;
  logic [31:0] mem [0:255];

  int n_chk = 0;
  int n_err = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_func3(m0_func3), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_func3(m1_func3), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata),
    .m0_stall(m0_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int n0, n1, nbad, nacc;
  logic [3:0] seq;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8] = 32'h12345678;
    rst = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_func3 = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_func3 = 0;

    // reset state, with a pending request that must not be granted
    m0_req = 1;
    #2;
    chk("rst_gnt", {31'd0, m0_gnt}, 0);
    chk("rst_stall", {31'd0, m0_stall}, 0);
    chk("rst_mem", {30'd0, mem_read, mem_write}, 0);
    tick; tick;
    m0_req = 0; rst = 1'b1;

    // m0 store 0x10 then load back
    tick;
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF; m0_func3 = 3'b010;
    #2;
    chk("st_gnt", {31'd0, m0_gnt}, 1);
    chk("st_stall", {31'd0, m0_stall}, 0);
    chk("st_idle_wr", {31'd0, mem_write}, 0);
    tick; m0_req = 0;
    #2;
    chk("st_acc_wr", {30'd0, mem_read, mem_write}, 32'd1);
    chk("st_acc_addr", mem_addr, 32'h10);
    chk("st_acc_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_acc_func3", {29'd0, mem_func3}, 32'd2);
    chk("st_acc_gnt", {31'd0, m0_gnt}, 0);
    tick; #2;
    chk("st_resp_wr", {31'd0, mem_write}, 0);
    chk("st_resp_addr", mem_addr, 0);
    chk("st_resp_rv", {31'd0, m0_rvalid}, 1);
    chk("st_resp_rd", m0_rdata, 0);
    tick;
    m0_req = 1; m0_we = 0;
    #2;
    chk("ld_gnt", {31'd0, m0_gnt}, 1);
    tick; m0_req = 0;
    #2;
    chk("ld_acc", {30'd0, mem_read, mem_write}, 32'd2);
    chk("ld_acc_rv", {31'd0, m0_rvalid}, 0);
    tick; #2;
    chk("ld_rv", {31'd0, m0_rvalid}, 1);
    chk("ld_rdata", m0_rdata, 32'hDEADBEEF);
    chk("ld_m1_rv", {31'd0, m1_rvalid}, 0);
    chk("ld_m1_rd", m1_rdata, 0);

    // m1 load alone
    tick;
    m1_req = 1; m1_we = 0; m1_addr = 32'h10;
    #2;
    chk("m1_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
    tick; m1_req = 0;
    #2;
    chk("m1_c1_gnt", {31'd0, m1_gnt}, 0);
    tick; #2;
    chk("m1_rv", {31'd0, m1_rvalid}, 1);
    chk("m1_rd", m1_rdata, 32'hDEADBEEF);
    chk("m1_m0_rv", {31'd0, m0_rvalid}, 0);
    chk("m1_m0_rd", m0_rdata, 0);

    // m0 pulse while m1 is in ACCESS: stalled and discarded
    tick;
    m1_req = 1; m1_addr = 32'h10;
    #2;
    chk("drop_m1_gnt", {31'd0, m1_gnt}, 1);
    tick;
    m1_req = 0; m0_req = 1; m0_we = 0; m0_addr = 32'h40;
    #2;
    chk("drop_stall", {31'd0, m0_stall}, 1);
    chk("drop_gnt", {31'd0, m0_gnt}, 0);
    chk("drop_addr", mem_addr, 32'h10);
    tick; m0_req = 0;
    #2;
    chk("drop_m1_rv", {31'd0, m1_rvalid}, 1);
    chk("drop_m0_rv", {31'd0, m0_rvalid}, 0);
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      tick; #2;
      nacc += int'(m0_gnt) + int'(mem_read) + int'(mem_write) + int'(m0_rvalid);
    end
    chk("drop_none", nacc, 0);

    // back-to-back m0 loads: grant every third cycle
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick;
      #2;
      chk($sformatf("b2b_gnt%0d", i), {31'd0, m0_gnt}, (i % 3 == 0) ? 32'd1 : 32'd0);
    end
    tick; m0_req = 0;
    tick;

    // reset during ACCESS of a store to 0x20
    tick;
    m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'hCAFEF00D;
    #2;
    chk("rs_gnt", {31'd0, m0_gnt}, 1);
    tick; m0_req = 0;
    chk("rs_acc_wr", {31'd0, mem_write}, 1);
    #1 rst = 1'b0;
    #1;
    chk("rs_wr_drop", {31'd0, mem_write}, 0);
    chk("rs_addr0", mem_addr, 0);
    m0_req = 1; m0_we = 0;
    tick; #2;
    chk("rs_hold_out", {27'd0, m0_gnt, m0_stall, m0_rvalid, mem_read, mem_write}, 0);
    chk("rs_hold_rd", m0_rdata | mem_addr | mem_wdata, 0);
    tick;
    rst = 1'b1;
    #2;
    chk("rs_ld_gnt", {31'd0, m0_gnt}, 1);
    tick; m0_req = 0;
    tick; #2;
    chk("rs_ld_rv", {31'd0, m0_rvalid}, 1);
    chk("rs_ld_old", m0_rdata, 32'h12345678);
    tick; rst = 1'b0;
    tick; rst = 1'b1;

    // both ports request together for 12 cycles
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_addr = 32'h10;
    n0 = 0; n1 = 0; nbad = 0; seq = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick;
      #2;
      if (m0_gnt) begin n0++; seq = {seq[2:0], 1'b0}; end
      if (m1_gnt) begin n1++; seq = {seq[2:0], 1'b1}; end
      if ((m0_gnt || m1_gnt) && (i % 3 != 0)) nbad++;
      if (m0_gnt && m1_gnt) nbad++;
    end
    m0_req = 0; m1_req = 0;
    chk("arb_offphase", nbad, 0);
`ifdef DMEM_ARB_RR_EN
    chk("arb_n0", n0, 2);
    chk("arb_n1", n1, 2);
    chk("arb_seq", {28'd0, seq}, 32'h5);
`else
    chk("arb_n0", n0, 4);
    chk("arb_n1", n1, 0);
    chk("arb_seq", {28'd0, seq}, 32'h0);
`endif
    tick; tick; tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
